// File: rtl/systolic_pkg.sv
// Shared types and constants for the 2x2 systolic correlation array.
// Optional build macro: SYSTOLIC_SAT_EN (saturating outputs instead of wrapping).
package systolic_pkg;

    localparam int DATA_W    = 8;
    localparam int ACC_W     = 20;
    localparam int TAPS      = 9;
    localparam int DRAIN_CYC = 2;

    typedef logic [3:0] tap_idx_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } ctrl_state_t;

    // Reduce an accumulator to an output pixel.
    function automatic logic [DATA_W-1:0] acc_to_out(input logic [ACC_W-1:0] acc);
`ifdef SYSTOLIC_SAT_EN
        if (acc > ACC_W'(255))
            return '1;
        return acc[DATA_W-1:0];
`else
        return acc[DATA_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: multiplies the incoming tap by the pixel its tap
// index selects from the local 3x3 window, accumulates, and forwards the tap
// (value, index, valid) one cycle later to its neighbours.
module systolic_pe
    import systolic_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_vld,
    input  logic [DATA_W-1:0]            i_tap,
    input  tap_idx_t                     i_idx,
    input  logic [TAPS-1:0][DATA_W-1:0]  i_win,
    output logic                         o_vld,
    output logic [DATA_W-1:0]            o_tap,
    output tap_idx_t                     o_idx,
    output logic [ACC_W-1:0]             o_acc
);

    logic [DATA_W-1:0]   w_pix;
    logic [2*DATA_W-1:0] w_prod;
    logic                r_vld;
    logic [DATA_W-1:0]   r_tap;
    tap_idx_t            r_idx;
    logic [ACC_W-1:0]    r_acc;

    assign w_pix  = (i_idx < 4'(TAPS)) ? i_win[i_idx] : '0;
    assign w_prod = w_pix * i_tap;

    // Accumulate only on valid taps; bubbles leave the sum untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (i_vld)
            r_acc <= r_acc + ACC_W'(w_prod);
    end

    // Skew register: forward the tap to right/lower neighbours next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_tap <= '0;
            r_idx <= '0;
        end else begin
            r_vld <= i_vld;
            r_tap <= i_tap;
            r_idx <= i_idx;
        end
    end

    assign o_vld = r_vld;
    assign o_tap = r_tap;
    assign o_idx = r_idx;
    assign o_acc = r_acc;

endmodule

// File: rtl/two_by_two_systolic.sv
// 2x2 systolic array computing a valid-mode 3x3 correlation over a 4x4 image.
// Runs one pass after reset release (RUN -> DRAIN -> DONE) and holds results.
// Optional build macro: SYSTOLIC_SAT_EN (saturating outputs instead of wrapping).
module two_by_two_systolic
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i00, i01, i02, i03,
    input  logic [DATA_W-1:0] i10, i11, i12, i13,
    input  logic [DATA_W-1:0] i20, i21, i22, i23,
    input  logic [DATA_W-1:0] i30, i31, i32, i33,
    input  logic [DATA_W-1:0] f00, f01, f02,
    input  logic [DATA_W-1:0] f10, f11, f12,
    input  logic [DATA_W-1:0] f20, f21, f22,
    output logic [DATA_W-1:0] o00,
    output logic [DATA_W-1:0] o01,
    output logic [DATA_W-1:0] o10,
    output logic [DATA_W-1:0] o11
);

    // Image index is 4*row+col, filter index is 3*row+col.
    logic [15:0][DATA_W-1:0]     w_img_in, w_img, r_img;
    logic [TAPS-1:0][DATA_W-1:0] w_flt_in, w_flt, r_flt;
    logic                        r_cap;

    ctrl_state_t r_state, w_state_nxt;
    tap_idx_t    r_cnt, w_cnt_nxt;
    logic        w_feed;

    // PE index p = 2*r + c.
    logic [3:0][TAPS-1:0][DATA_W-1:0] w_win;
    logic [3:0]                       w_in_vld, w_fwd_vld;
    logic [3:0][DATA_W-1:0]           w_in_tap, w_fwd_tap;
    tap_idx_t [3:0]                   w_in_idx, w_fwd_idx;
    logic [3:0][ACC_W-1:0]            w_acc;
    logic [3:0][DATA_W-1:0]           r_out;
    logic                             w_unused_fwd;

    assign w_img_in = {i33, i32, i31, i30, i23, i22, i21, i20,
                       i13, i12, i11, i10, i03, i02, i01, i00};
    assign w_flt_in = {f22, f21, f20, f12, f11, f10, f02, f01, f00};

    // Snapshot the inputs on cycle 1 so later input changes cannot disturb the pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap <= 1'b0;
            r_img <= '0;
            r_flt <= '0;
        end else if (!r_cap) begin
            r_cap <= 1'b1;
            r_img <= w_img_in;
            r_flt <= w_flt_in;
        end
    end

    // Cycle 1 consumes the live ports; every later cycle uses the snapshot.
    assign w_img = r_cap ? r_img : w_img_in;
    assign w_flt = r_cap ? r_flt : w_flt_in;

    // Controller state and shared tap/drain counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: feed 9 taps, flush the 2-cycle skew, then park in DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_feed      = 1'b0;
        case (r_state)
            S_RUN: begin
                w_feed = 1'b1;
                if (r_cnt == 4'(TAPS - 1)) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DRAIN: begin
                if (r_cnt == 4'(DRAIN_CYC - 1)) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DONE:  ;
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Window of PE(r,c): entry 3a+b is pixel (r+a, c+b).
    for (genvar r = 0; r < 2; r++) begin : g_row
        for (genvar c = 0; c < 2; c++) begin : g_col
            for (genvar a = 0; a < 3; a++) begin : g_wa
                for (genvar b = 0; b < 3; b++) begin : g_wb
                    assign w_win[2*r+c][3*a+b] = w_img[4*(r+a)+(c+b)];
                end
            end
        end
    end

    // Tap skew: PE00 from the controller, PE01/PE10 from PE00, PE11 from PE10.
    assign w_in_vld[0] = w_feed;
    assign w_in_tap[0] = w_flt[r_cnt];
    assign w_in_idx[0] = r_cnt;
    assign w_in_vld[1] = w_fwd_vld[0];
    assign w_in_tap[1] = w_fwd_tap[0];
    assign w_in_idx[1] = w_fwd_idx[0];
    assign w_in_vld[2] = w_fwd_vld[0];
    assign w_in_tap[2] = w_fwd_tap[0];
    assign w_in_idx[2] = w_fwd_idx[0];
    assign w_in_vld[3] = w_fwd_vld[2];
    assign w_in_tap[3] = w_fwd_tap[2];
    assign w_in_idx[3] = w_fwd_idx[2];

    // PE01 and PE11 sit on the array edge; their forwarded taps go nowhere.
    assign w_unused_fwd = ^{w_fwd_vld[1], w_fwd_tap[1], w_fwd_idx[1],
                            w_fwd_vld[3], w_fwd_tap[3], w_fwd_idx[3]};

    for (genvar p = 0; p < 4; p++) begin : g_pe
        systolic_pe u_pe (
            .clk   (clk),
            .rst   (rst),
            .i_vld (w_in_vld[p]),
            .i_tap (w_in_tap[p]),
            .i_idx (w_in_idx[p]),
            .i_win (w_win[p]),
            .o_vld (w_fwd_vld[p]),
            .o_tap (w_fwd_tap[p]),
            .o_idx (w_fwd_idx[p]),
            .o_acc (w_acc[p])
        );
    end

    // Accumulators are frozen once in DONE, so reloading every DONE cycle holds them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_out <= '0;
        else if (r_state == S_DONE)
            for (int p = 0; p < 4; p++)
                r_out[p] <= acc_to_out(w_acc[p]);
    end

    assign o00 = r_out[0];
    assign o01 = r_out[1];
    assign o10 = r_out[2];
    assign o11 = r_out[3];

endmodule

// File: tb/tb_two_by_two_systolic.sv
// Directed bench for two_by_two_systolic; expected values hand-computed.
module tb_two_by_two_systolic;
    import systolic_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] img [4][4];
    logic [7:0] flt [3][3];
    logic [7:0] o00, o01, o10, o11;
    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    two_by_two_systolic dut (
        .clk(clk), .rst(rst),
        .i00(img[0][0]), .i01(img[0][1]), .i02(img[0][2]), .i03(img[0][3]),
        .i10(img[1][0]), .i11(img[1][1]), .i12(img[1][2]), .i13(img[1][3]),
        .i20(img[2][0]), .i21(img[2][1]), .i22(img[2][2]), .i23(img[2][3]),
        .i30(img[3][0]), .i31(img[3][1]), .i32(img[3][2]), .i33(img[3][3]),
        .f00(flt[0][0]), .f01(flt[0][1]), .f02(flt[0][2]),
        .f10(flt[1][0]), .f11(flt[1][1]), .f12(flt[1][2]),
        .f20(flt[2][0]), .f21(flt[2][1]), .f22(flt[2][2]),
        .o00(o00), .o01(o01), .o10(o10), .o11(o11)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tot++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input int e00, input int e01,
                        input int e10, input int e11);
        chk({tag, ".o00"}, o00, e00);
        chk({tag, ".o01"}, o01, e01);
        chk({tag, ".o10"}, o10, e10);
        chk({tag, ".o11"}, o11, e11);
    endtask

    task automatic load_plan();
        img[0] = '{8'd8, 8'd3, 8'd9, 8'd1};
        img[1] = '{8'd7, 8'd7, 8'd2, 8'd8};
        img[2] = '{8'd5, 8'd6, 8'd3, 8'd1};
        img[3] = '{8'd4, 8'd9, 8'd2, 8'd6};
        flt[0] = '{8'd1, 8'd5, 8'd8};
        flt[1] = '{8'd6, 8'd0, 8'd7};
        flt[2] = '{8'd3, 8'd1, 8'd2};
    endtask

    // Reset for 3 cycles (30 ns), release at a falling edge; next rising edge is cycle 1.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Run cycles 1..12 after release: zero through cycle 11, results at 12.
    task automatic run_pass(input string tag, input int e00, input int e01,
                            input int e10, input int e11);
        repeat (11) @(posedge clk);
        #1 chk4({tag, ".c11"}, 0, 0, 0, 0);
        @(posedge clk);
        #1 chk4({tag, ".c12"}, e00, e01, e10, e11);
    endtask

    initial begin
        int sat_exp;
        load_plan();
        #1 chk4("reset", 0, 0, 0, 0);

        // Test-plan vectors.
        do_reset();
        run_pass("plan", 178, 177, 134, 165);
        repeat (50) @(posedge clk);
        #1 chk4("plan.hold", 178, 177, 134, 165);

        // Late input changes are ignored.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = 8'd200;
        repeat (5) @(posedge clk);
        #1 chk4("plan.late", 178, 177, 134, 165);

        // Asynchronous reset clears outputs before any clock edge.
        load_plan();
        @(negedge clk);
        rst = 1'b1;
        #1 chk4("async_rst", 0, 0, 0, 0);

        // Identity filter; filter zeroed after cycle 2 must not matter.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = 8'(16 * r + c);
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                flt[a][b] = 8'd0;
        flt[1][1] = 8'd1;
        do_reset();
        repeat (2) @(posedge clk);
        #1 flt[1][1] = 8'd0;
        repeat (9) @(posedge clk);
        #1 chk4("ident.c11", 0, 0, 0, 0);
        @(posedge clk);
        #1 chk4("ident.c12", 17, 18, 33, 34);

        // All-255 corner: 585225 wraps to 9, saturates to 255.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[r][c] = 8'd255;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                flt[a][b] = 8'd255;
`ifdef SYSTOLIC_SAT_EN
        sat_exp = 255;
`else
        sat_exp = 9;
`endif
        do_reset();
        run_pass("max", sat_exp, sat_exp, sat_exp, sat_exp);

        // Reset pulsed mid-pass at cycle 5, then full recompute.
        load_plan();
        do_reset();
        repeat (5) @(posedge clk);
        #1 chk4("mid.c5", 0, 0, 0, 0);
        do_reset();
        run_pass("mid", 178, 177, 134, 165);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
